riscv_multicycle_ctrl: RTL and testbench

//  Multicycle RV32I control unit: a Moore FSM sequencing fetch/decode/execute/writeback over one shared memory and ALU.

---
 rtl/riscv_ctrl_pkg.sv | 86 ++++++++
 rtl/riscv_multicycle_ctrl_branch_resolve.sv | 23 ++
 rtl/riscv_multicycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states,
// datapath mux codes and the internal control bundle.
package riscv_ctrl_pkg;

    localparam int unsigned OP_W    = 7;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_LW     = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW     = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OP_W-1:0] OP_OPIMM  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
    localparam logic [STATE_W-1:0] S_MEMADR   = 4'd2;
    localparam logic [STATE_W-1:0] S_MEMREAD  = 4'd3;
    localparam logic [STATE_W-1:0] S_MEMWB    = 4'd4;
    localparam logic [STATE_W-1:0] S_MEMWRITE = 4'd5;
    localparam logic [STATE_W-1:0] S_EXEC_R   = 4'd6;
    localparam logic [STATE_W-1:0] S_EXEC_I   = 4'd7;
    localparam logic [STATE_W-1:0] S_EXEC_U   = 4'd8;
    localparam logic [STATE_W-1:0] S_ALUWB    = 4'd9;
    localparam logic [STATE_W-1:0] S_JAL      = 4'd10;
    localparam logic [STATE_W-1:0] S_JALR     = 4'd11;
    localparam logic [STATE_W-1:0] S_JALR_WB  = 4'd12;
    localparam logic [STATE_W-1:0] S_BRANCH   = 4'd13;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Per-state control bundle decoded from the FSM state.
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       illegal;
        logic       retire;
    } ctrl_t;

    // Immediate format depends only on the opcode, independent of state.
    function automatic logic [2:0] imm_src_of(input logic [OP_W-1:0] op);
        logic [2:0] imm;
        imm = IMM_I;
        case (op)
            OP_LW, OP_OPIMM, OP_JALR: imm = IMM_I;
            OP_SW:                    imm = IMM_S;
            OP_BRANCH:                imm = IMM_B;
            OP_JAL:                   imm = IMM_J;
            OP_LUI:                   imm = IMM_U;
            default:                  imm = 3'b000;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_branch_resolve.sv
// Branch condition evaluation from funct3 and the ALU compare flags.
module branch_resolve (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control FSM with retired-instruction counter.
// Optional memory wait states via RV_MC_CTRL_MEM_READY_EN.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned IMMSRC_W = 3,
    parameter int unsigned ALUOP_W  = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                zero,
    input  logic                lt,
    input  logic                ltu,
`ifdef RV_MC_CTRL_MEM_READY_EN
    input  logic                mem_ready,
`endif
    output logic                pc_write,
    output logic                adr_src,
    output logic                mem_write,
    output logic                ir_write,
    output logic [1:0]          result_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [IMMSRC_W-1:0] imm_src,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                reg_write,
    output logic                illegal,
    output logic [CNT_W-1:0]    instret
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] cur;
    logic [STATE_W-1:0] next_state;
    ctrl_t              ctrl;
    logic               taken;
    logic               ready;

`ifdef RV_MC_CTRL_MEM_READY_EN
    assign ready = mem_ready;
`else
    assign ready = 1'b1;
`endif

    branch_resolve u_branch_resolve (
        .funct3 (funct3),
        .zero   (zero),
        .lt     (lt),
        .ltu    (ltu),
        .taken  (taken)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next_state;
    end

    // During reset the mux selects mirror FETCH; write enables are gated below.
    assign cur = rst_n ? state : S_FETCH;

    always_comb begin
        next_state = cur;
        ctrl       = '0;
        case (cur)
            S_FETCH: begin
                ctrl.ir_write   = ready;
                ctrl.pc_update  = ready;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                if (ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXEC_R;
                    OP_OPIMM:     next_state = S_EXEC_I;
                    OP_LUI:       next_state = S_EXEC_U;
                    OP_JAL:       next_state = S_JAL;
                    OP_JALR:      next_state = S_JALR;
                    OP_BRANCH:    next_state = S_BRANCH;
                    default: begin
                        next_state   = S_FETCH;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                next_state     = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
                if (ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
                next_state      = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                if (ready) begin
                    ctrl.retire = 1'b1;
                    next_state  = S_FETCH;
                end
            end
            S_EXEC_R, S_EXEC_I, S_EXEC_U: begin
                ctrl.alu_src_a = (cur == S_EXEC_U) ? SRCA_ZERO : SRCA_RS1;
                ctrl.alu_src_b = (cur == S_EXEC_R) ? SRCB_RS2 : SRCB_IMM;
                ctrl.alu_op    = (cur == S_EXEC_U) ? ALUOP_ADD : ALUOP_FUNCT;
                next_state     = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
                next_state      = S_FETCH;
            end
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
                next_state      = S_ALUWB;
            end
            S_JALR: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.result_src = RES_ALURESULT;
                ctrl.pc_update  = 1'b1;
                next_state      = S_JALR_WB;
            end
            S_JALR_WB: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURESULT;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
                next_state      = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.retire     = 1'b1;
                next_state      = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)           instret <= '0;
        else if (ctrl.retire) instret <= instret + CNT_W'(1);
    end

    assign pc_write   = rst_n & (ctrl.pc_update | (ctrl.branch & taken));
    assign mem_write  = rst_n & ctrl.mem_write;
    assign ir_write   = rst_n & ctrl.ir_write;
    assign reg_write  = rst_n & ctrl.reg_write;
    assign adr_src    = ctrl.adr_src;
    assign result_src = ctrl.result_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ALUOP_W'(ctrl.alu_op);
    assign illegal    = ctrl.illegal;
    assign imm_src    = IMMSRC_W'(imm_src_of(op));

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: stimulus queues per-cycle expected
// control words, a negedge monitor pops and compares them.
module tb_riscv_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero, lt, ltu;
`ifdef RV_MC_CTRL_MEM_READY_EN
    logic       mem_ready;
`endif
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic [3:0] instret;

    always #5 clk = ~clk;

    riscv_multicycle_ctrl #(.IMMSRC_W(3), .ALUOP_W(2), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
`ifdef RV_MC_CTRL_MEM_READY_EN
        .mem_ready  (mem_ready),
`endif
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .illegal    (illegal),
        .instret    (instret)
    );

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       illegal;
        logic [3:0] instret;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    logic [3:0] cnt;

    function automatic exp_t mk(input logic pcw, input logic adr, input logic mw,
                                input logic irw, input logic [1:0] rs,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic [2:0] imm, input logic [1:0] alu,
                                input logic rw, input logic ill);
        exp_t e;
        e.pc_write   = pcw;
        e.adr_src    = adr;
        e.mem_write  = mw;
        e.ir_write   = irw;
        e.result_src = rs;
        e.alu_src_a  = a;
        e.alu_src_b  = b;
        e.imm_src    = imm;
        e.alu_op     = alu;
        e.reg_write  = rw;
        e.illegal    = ill;
        e.instret    = cnt;
        return e;
    endfunction

    task automatic push(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [6:0] o, input logic [2:0] f3,
                         input logic z, input logic l, input logic lu);
        op = o; funct3 = f3; zero = z; lt = l; ltu = lu;
    endtask

    task automatic push_fd(input string nm, input logic [2:0] imm, input logic ill);
        push({nm, "_fetch"},  mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 2'b00, 0, 0));
        push({nm, "_decode"}, mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 2'b00, 0, ill));
    endtask

    task automatic do_lw();
        setup(7'b0000011, 3'b010, 0, 0, 0);
        push_fd("lw", 3'b000, 0);
        push("lw_memadr",  mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
        push("lw_memread", mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
        push("lw_memwb",   mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0));
        run(5);
        cnt = cnt + 4'd1;
    endtask

    task automatic do_sw();
        setup(7'b0100011, 3'b010, 0, 0, 0);
        push_fd("sw", 3'b001, 0);
        push("sw_memadr",   mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 2'b00, 0, 0));
        push("sw_memwrite", mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b001, 2'b00, 0, 0));
        run(4);
        cnt = cnt + 4'd1;
    endtask

    // R-type, addi and lui share the EXEC -> ALUWB shape.
    task automatic do_alu(input string nm, input logic [6:0] o, input logic [2:0] imm,
                          input logic [1:0] a, input logic [1:0] b, input logic [1:0] alu);
        setup(o, 3'b000, 0, 0, 0);
        push_fd(nm, imm, 0);
        push({nm, "_exec"},  mk(0, 0, 0, 0, 2'b00, a, b, imm, alu, 0, 0));
        push({nm, "_aluwb"}, mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 2'b00, 1, 0));
        run(4);
        cnt = cnt + 4'd1;
    endtask

    task automatic do_jal();
        setup(7'b1101111, 3'b000, 0, 0, 0);
        push_fd("jal", 3'b011, 0);
        push("jal_jal",   mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b011, 2'b00, 0, 0));
        push("jal_aluwb", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b011, 2'b00, 1, 0));
        run(4);
        cnt = cnt + 4'd1;
    endtask

    task automatic do_jalr();
        setup(7'b1100111, 3'b000, 0, 0, 0);
        push_fd("jalr", 3'b000, 0);
        push("jalr_jalr", mk(1, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
        push("jalr_wb",   mk(0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 3'b000, 2'b00, 1, 0));
        run(4);
        cnt = cnt + 4'd1;
    endtask

    task automatic do_br(input string nm, input logic [2:0] f3, input logic z,
                         input logic l, input logic lu, input logic tk);
        setup(7'b1100011, f3, z, l, lu);
        push_fd(nm, 3'b010, 0);
        push({nm, "_branch"}, mk(tk, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 2'b01, 0, 0));
        run(3);
        cnt = cnt + 4'd1;
    endtask

    task automatic do_illegal(input string nm);
        setup(7'b1111111, 3'b000, 0, 0, 0);
        push_fd(nm, 3'b000, 1);
        run(2);
    endtask

    always @(negedge clk) begin
        exp_t  e;
        exp_t  a;
        string nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a.pc_write   = pc_write;
            a.adr_src    = adr_src;
            a.mem_write  = mem_write;
            a.ir_write   = ir_write;
            a.result_src = result_src;
            a.alu_src_a  = alu_src_a;
            a.alu_src_b  = alu_src_b;
            a.imm_src    = imm_src;
            a.alu_op     = alu_op;
            a.reg_write  = reg_write;
            a.illegal    = illegal;
            a.instret    = instret;
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b (pcw,adr,mw,irw,rs,a,b,imm,alu,rw,ill,instret)",
                         nm, a, e);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        cnt   = 4'd0;
        setup(7'b0110011, 3'b000, 0, 0, 0);
`ifdef RV_MC_CTRL_MEM_READY_EN
        mem_ready = 1'b1;
`endif
        run(2);
        push("reset_hold", mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
        run(1);
        rst_n = 1'b1;

        do_lw();
        do_sw();

        // Abandon an R-type in EXEC_R: reset cycle must carry no writes.
        setup(7'b0110011, 3'b000, 0, 0, 0);
        push_fd("r_abort", 3'b000, 0);
        run(2);
        rst_n = 1'b0;
        push("r_abort_rst", mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
        run(1);
        rst_n = 1'b1;
        cnt   = 4'd0;

        do_alu("r",    7'b0110011, 3'b000, 2'b10, 2'b00, 2'b10);
        do_alu("addi", 7'b0010011, 3'b000, 2'b10, 2'b01, 2'b10);
        do_alu("lui",  7'b0110111, 3'b100, 2'b11, 2'b01, 2'b00);
        do_jal();
        do_jalr();

        do_br("bne_nz",  3'b001, 0, 0, 0, 1);
        do_br("bne_z",   3'b001, 1, 0, 0, 0);
        do_br("beq_z",   3'b000, 1, 0, 0, 1);
        do_br("blt_lt",  3'b100, 0, 1, 0, 1);
        do_br("bge_lt",  3'b101, 0, 1, 0, 0);
        do_br("bltu_lu", 3'b110, 0, 0, 1, 1);
        do_br("bgeu_nl", 3'b111, 0, 0, 0, 1);
        do_br("f3_010",  3'b010, 1, 1, 1, 0);

        do_illegal("illegal_a");

        // Three more retirements bring the 4-bit counter to 16 -> 0.
        do_alu("r2", 7'b0110011, 3'b000, 2'b10, 2'b00, 2'b10);
        do_lw();
        do_sw();
        do_illegal("wrap_check");

`ifdef RV_MC_CTRL_MEM_READY_EN
        setup(7'b0100011, 3'b010, 0, 0, 0);
        push_fd("sw_wait", 3'b001, 0);
        push("sw_wait_memadr", mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 2'b00, 0, 0));
        for (int i = 0; i < 4; i++)
            push("sw_wait_memwrite", mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b001, 2'b00, 0, 0));
        run(3);
        mem_ready = 1'b0;
        run(3);
        mem_ready = 1'b1;
        run(1);
        cnt = cnt + 4'd1;
        do_illegal("after_wait");
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
